pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Hazard and pipeline-sequencing controller for the five-stage RISC toy core. It watches register addresses and control bits in the D, E, M and W stages and drives the stall, flush and forwarding controls for the FD, DE, EM and MW pipeline registers. It inserts the load-use bubble, squashes wrong-path instructions after a taken branch or jump, and freezes the pipeline while a multi-cycle data-memory access is outstanding. It also keeps a sticky memory-timeout flag and a saturating stall-cycle counter.

## Interface
- TIMEOUT, 16, maximum number of wait cycles tolerated for one data-memory access (≥2).
- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- RA0_D, RA1_D  in  5 each  source register addresses in D.
- Use0_D, Use1_D  in  1 each  source operand actually read by the D instruction.
- RA0_E, RA1_E  in  5 each  source register addresses in E.
- WA_E, WA_M, WA_W  in  5 each  destination addresses in E, M and W.
- WEN_E, WEN_M, WEN_W  in  1 each  register write enable; active-low (0 = writes).
- Load_E, Load_M  in  1 each  the instruction is a load.
- BrTaken_E  in  1  taken branch or jump resolved in E.
- DREQ_M  in  1  data-memory request in M; active-low.
- DRDY  in  1  data memory has completed the current access; active-high.
- PCWrite  out  1  PC update enable.
- FDStall  out  1  hold the FD register.
- FDFlush  out  1  clear FD to a bubble.
- DEStall  out  1  hold the DE register.
- DEFlush  out  1  clear DE to a bubble (WEN=1, DREQ=1).
- EMStall  out  1  hold the EM register.
- MWFlush  out  1  load a bubble into MW.
- Fwd0_E, Fwd1_E  out  2 each  operand source for E: 0 = regfile/DE value, 1 = M-stage ALU result, 2 = W-stage write-back value.
- MemErr  out  1  sticky flag: a memory access timed out.
- StallCnt  out  16  count of stall cycles; saturates.

## Operation
- The FSM has two states. It resets to RUN.
  - RUN: normal flow.
  - WAIT: a data-memory access is outstanding.
- A wait counter WCnt (clog2(TIMEOUT) bits) runs only in WAIT.
- MemHold = (RUN & ~DREQ_M & ~DRDY) | (WAIT & ~DRDY & ~(WCnt == TIMEOUT-1)).
- FSM transitions:
  - RUN→WAIT when ~DREQ_M & ~DRDY. WCnt is loaded with 0.
  - WAIT→RUN when DRDY = 1, or when WCnt == TIMEOUT-1. In the timeout case MemErr is set to 1 and stays 1 until reset.
  - Otherwise WAIT holds and WCnt increments.
- Load-use hazard: LU = Load_E & ~WEN_E & ((Use0_D & RA0_D == WA_E) | (Use1_D & RA1_D == WA_E)).
- Outputs are evaluated in priority order; the first matching case applies.
  1. MemHold: PCWrite=0, FDStall=1, DEStall=1, EMStall=1, MWFlush=1, all flushes 0. A pending BrTaken_E or LU is held and takes effect once MemHold drops.
  2. BrTaken_E: PCWrite=1, FDFlush=1, DEFlush=1. A simultaneous LU is ignored because D is on the wrong path.
  3. LU: PCWrite=0, FDStall=1, DEFlush=1 for exactly one cycle.
  4. Otherwise: PCWrite=1 and all stall/flush outputs 0.
- Forwarding for operand n:
  - Fwdn_E = 1 if ~WEN_M & ~Load_M & WA_M == RAn_E.
  - Else Fwdn_E = 2 if ~WEN_W & WA_W == RAn_E.
  - Else Fwdn_E = 0.
  - M takes priority over W. All 32 registers are forwardable.
  - Forwarding selects are computed regardless of stalls.
- StallCnt increments on every clock edge where PCWrite was 0, and holds at 16'hFFFF once reached.

## Timing
- All control outputs are combinational from the current state and inputs, settling within the same cycle. State, WCnt, MemErr and StallCnt are registered.
- While RSTN = 0, outputs are forced: PCWrite=0, FDStall=0, FDFlush=1, DEStall=0, DEFlush=1, EMStall=0, MWFlush=1, Fwd0_E=Fwd1_E=0, MemErr=0, StallCnt=0. State is RUN and WCnt=0.
- Load-use penalty is 1 cycle. After it, the consumer sits in E with the load in W, giving Fwd=2.
- A memory access with DRDY=1 in its first M cycle causes no stall.
- An access completing k cycles late stalls for k cycles. The pipeline resumes in the same cycle DRDY rises.
- On timeout, the stall lasts exactly TIMEOUT cycles and the pipeline proceeds in the cycle WCnt == TIMEOUT-1.
- Reset asserted mid-WAIT immediately returns to RUN and clears WCnt, MemErr and StallCnt.

## Test plan
- LW r3 in E (Load_E=1, WEN_E=0, WA_E=3), D uses r3 (RA1_D=3, Use1_D=1) -> one cycle of PCWrite=0, FDStall=1, DEFlush=1. Next cycle the consumer is in E with Fwd1_E=2. StallCnt=1.
- ADD writing r5 in M, r5 also written in W, RA0_E=5 -> Fwd0_E=1. Set Load_M=1 -> Fwd0_E=2.
- BrTaken_E=1 together with LU=1 -> FDFlush=1, DEFlush=1, PCWrite=1, no stall.
- DREQ_M=0 with DRDY low for 3 cycles -> PCWrite=0, FDStall=DEStall=EMStall=MWFlush=1 for 3 cycles. Normal flow resumes in the cycle DRDY=1. MemErr stays 0.
- TIMEOUT=4, DRDY never rises -> exactly 4 stall cycles, then MemErr=1 sticky and FSM back in RUN.
- RSTN pulsed low mid-WAIT -> all outputs take their reset values asynchronously. After release, FSM is in RUN with StallCnt=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Hazard and sequencing controller for the five-stage RISC toy core.
//   It inserts the load-use bubble, squashes the wrong path after a taken
//   branch or jump, and freezes the pipeline while a data-memory access is
//   outstanding. It also forwards operands to E, keeps a sticky memory-timeout
//   flag and a saturating stall-cycle counter.
//
// Parameters
//   TIMEOUT   maximum wait cycles tolerated for one data-memory access (>= 2)
//
// Ports
//   CLK, RSTN                 clock (rising edge), async active-low reset
//   RA0_D, RA1_D, Use0_D/1_D  source regs of the D instruction and read flags
//   RA0_E, RA1_E              source regs of the E instruction
//   WA_E/M/W, WEN_E/M/W       destination regs and active-low write enables
//   Load_E, Load_M            load instruction in E / M
//   BrTaken_E                 taken branch or jump resolved in E
//   DREQ_M (active-low), DRDY data-memory request in M / access completed
//   PCWrite, FDStall, FDFlush, DEStall, DEFlush, EMStall, MWFlush
//                             pipeline register controls
//   Fwd0_E, Fwd1_E            operand source: 0 regfile, 1 M result, 2 W value
//   MemErr                    sticky memory-timeout flag
//   StallCnt                  saturating count of cycles with PCWrite = 0
//   dbg_state                 current FSM state (0 = RUN, 1 = WAIT)
//
// Handshake: the data memory is a request/complete pair. A request is
// presented while DREQ_M is low; the access completes in the cycle DRDY is
// high. While the request is pending and DRDY is low the whole pipeline is
// frozen, so DREQ_M and every M-stage input stay stable until completion or
// until TIMEOUT stall cycles have elapsed, whichever comes first.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [4:0]  RA0_D,
    input  logic [4:0]  RA1_D,
    input  logic        Use0_D,
    input  logic        Use1_D,
    input  logic [4:0]  RA0_E,
    input  logic [4:0]  RA1_E,
    input  logic [4:0]  WA_E,
    input  logic [4:0]  WA_M,
    input  logic [4:0]  WA_W,
    input  logic        WEN_E,
    input  logic        WEN_M,
    input  logic        WEN_W,
    input  logic        Load_E,
    input  logic        Load_M,
    input  logic        BrTaken_E,
    input  logic        DREQ_M,
    input  logic        DRDY,
    output logic        PCWrite,
    output logic        FDStall,
    output logic        FDFlush,
    output logic        DEStall,
    output logic        DEFlush,
    output logic        EMStall,
    output logic        MWFlush,
    output logic [1:0]  Fwd0_E,
    output logic [1:0]  Fwd1_E,
    output logic        MemErr,
    output logic [15:0] StallCnt,
    output logic        dbg_state
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          set_err;
    logic          mem_err_q;
    logic [15:0]   stall_cnt_q;
    logic          wcnt_last;
    logic          mem_hold;
    logic          load_use;
    logic          pc_write_raw;

    assign wcnt_last = (wcnt == WLAST);

    // Pipeline freeze: a fresh request that is not served in its first
    // cycle, or an outstanding one that has neither completed nor run out
    // of patience. The last wait cycle releases the pipeline on its own.
    assign mem_hold = ((state == ST_RUN)  & ~DREQ_M & ~DRDY) |
                      ((state == ST_WAIT) & ~DRDY & ~wcnt_last);

    assign load_use = Load_E & ~WEN_E &
                      ((Use0_D & (RA0_D == WA_E)) | (Use1_D & (RA1_D == WA_E)));

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= ST_RUN;
            wcnt        <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (set_err) begin
                mem_err_q <= 1'b1;
            end
            if (!pc_write_raw && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = '0;
        set_err   = 1'b0;
        case (state)
            ST_RUN: begin
                if (~DREQ_M & ~DRDY) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (DRDY) begin
                    state_nxt = ST_RUN;
                end else if (wcnt_last) begin
                    // Gave up on the access: let the pipeline go on.
                    state_nxt = ST_RUN;
                    set_err   = 1'b1;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // ---------------- output logic ----------------
    // Priority: memory freeze, then taken branch (D is on the wrong path so
    // a load-use hit there is irrelevant), then load-use bubble.
    always_comb begin
        pc_write_raw = 1'b1;
        FDStall      = 1'b0;
        FDFlush      = 1'b0;
        DEStall      = 1'b0;
        DEFlush      = 1'b0;
        EMStall      = 1'b0;
        MWFlush      = 1'b0;
        if (mem_hold) begin
            pc_write_raw = 1'b0;
            FDStall      = 1'b1;
            DEStall      = 1'b1;
            EMStall      = 1'b1;
            MWFlush      = 1'b1;
        end else if (BrTaken_E) begin
            FDFlush      = 1'b1;
            DEFlush      = 1'b1;
        end else if (load_use) begin
            pc_write_raw = 1'b0;
            FDStall      = 1'b1;
            DEFlush      = 1'b1;
        end

        PCWrite = pc_write_raw;
        // In reset the pipeline registers are filled with bubbles.
        if (!RSTN) begin
            PCWrite = 1'b0;
            FDStall = 1'b0;
            FDFlush = 1'b1;
            DEStall = 1'b0;
            DEFlush = 1'b1;
            EMStall = 1'b0;
            MWFlush = 1'b1;
        end
    end

    // ---------------- forwarding ----------------
    // A load in M has no result yet, so it cannot forward from M.
    always_comb begin
        Fwd0_E = 2'd0;
        Fwd1_E = 2'd0;
        if (~WEN_M & ~Load_M & (WA_M == RA0_E)) begin
            Fwd0_E = 2'd1;
        end else if (~WEN_W & (WA_W == RA0_E)) begin
            Fwd0_E = 2'd2;
        end
        if (~WEN_M & ~Load_M & (WA_M == RA1_E)) begin
            Fwd1_E = 2'd1;
        end else if (~WEN_W & (WA_W == RA1_E)) begin
            Fwd1_E = 2'd2;
        end
        if (!RSTN) begin
            Fwd0_E = 2'd0;
            Fwd1_E = 2'd0;
        end
    end

    assign MemErr    = mem_err_q;
    assign StallCnt  = stall_cnt_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed scenarios for load-use, forwarding, branch squash, memory wait,
//   timeout and reset, followed by randomized cycles checked against a
//   cycle-level reference model of the controller rules.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int TIMEOUT = 4;

  localparam logic [6:0] C_NORM  = 7'b1000000;
  localparam logic [6:0] C_LU    = 7'b0100100;
  localparam logic [6:0] C_HOLD  = 7'b0101011;
  localparam logic [6:0] C_BR    = 7'b1010100;
  localparam logic [6:0] C_RESET = 7'b0010101;

  logic        CLK, RSTN;
  logic [4:0]  RA0_D, RA1_D, RA0_E, RA1_E, WA_E, WA_M, WA_W;
  logic        Use0_D, Use1_D, WEN_E, WEN_M, WEN_W, Load_E, Load_M;
  logic        BrTaken_E, DREQ_M, DRDY;
  logic        PCWrite, FDStall, FDFlush, DEStall, DEFlush, EMStall, MWFlush;
  logic [1:0]  Fwd0_E, Fwd1_E;
  logic        MemErr, dbg_state;
  logic [15:0] StallCnt;
  logic [6:0]  ctrl;

  int checks;
  int failures;

  assign ctrl = {PCWrite, FDStall, FDFlush, DEStall, DEFlush, EMStall, MWFlush};

  pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .RA0_D(RA0_D), .RA1_D(RA1_D), .Use0_D(Use0_D), .Use1_D(Use1_D),
    .RA0_E(RA0_E), .RA1_E(RA1_E),
    .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
    .WEN_E(WEN_E), .WEN_M(WEN_M), .WEN_W(WEN_W),
    .Load_E(Load_E), .Load_M(Load_M), .BrTaken_E(BrTaken_E),
    .DREQ_M(DREQ_M), .DRDY(DRDY),
    .PCWrite(PCWrite), .FDStall(FDStall), .FDFlush(FDFlush),
    .DEStall(DEStall), .DEFlush(DEFlush), .EMStall(EMStall), .MWFlush(MWFlush),
    .Fwd0_E(Fwd0_E), .Fwd1_E(Fwd1_E), .MemErr(MemErr), .StallCnt(StallCnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    RA0_D = 0; RA1_D = 0; Use0_D = 0; Use1_D = 0;
    RA0_E = 0; RA1_E = 0; WA_E = 0; WA_M = 0; WA_W = 0;
    WEN_E = 1; WEN_M = 1; WEN_W = 1; Load_E = 0; Load_M = 0;
    BrTaken_E = 0; DREQ_M = 1; DRDY = 0;
  endtask

  // Leaves the bench 1 ns after a rising edge with reset released.
  task automatic do_reset();
    RSTN = 0;
    set_idle();
    @(posedge CLK); #1;
    RSTN = 1;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RSTN = 0;
    set_idle();
    WEN_M = 0; WA_M = 2; RA0_E = 2; WEN_W = 0; WA_W = 3; RA1_E = 3;
    #3;
    checks++; if (ctrl !== C_RESET) begin failures++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RESET); end
    checks++; if (Fwd0_E !== 2'd0 || Fwd1_E !== 2'd0) begin failures++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", Fwd0_E, Fwd1_E); end
    checks++; if (StallCnt !== 16'd0 || MemErr !== 1'b0 || dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state: cnt=%0d err=%0d st=%0d expected 0/0/0", StallCnt, MemErr, dbg_state); end
    set_idle();
    @(posedge CLK); @(posedge CLK); #1;
    RSTN = 1;
    @(negedge CLK);
    checks++; if (ctrl !== C_NORM) begin failures++; $display("FAIL reset_release_ctrl: got %b expected %b", ctrl, C_NORM); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    Load_E = 1; WEN_E = 0; WA_E = 3; RA1_D = 3; Use1_D = 1; RA0_D = 7;
    @(negedge CLK);
    checks++; if (ctrl !== C_LU) begin failures++; $display("FAIL lu_bubble: got %b expected %b", ctrl, C_LU); end
    next_cycle();
    Load_E = 0; WEN_E = 1; WA_E = 0;
    @(negedge CLK);
    checks++; if (ctrl !== C_NORM) begin failures++; $display("FAIL lu_one_cycle: got %b expected %b", ctrl, C_NORM); end
    checks++; if (StallCnt !== 16'd1) begin failures++; $display("FAIL lu_stallcnt: got %0d expected 1", StallCnt); end
    next_cycle();
    Use1_D = 0; RA1_D = 0; RA1_E = 3; WEN_M = 1; WA_W = 3; WEN_W = 0;
    @(negedge CLK);
    checks++; if (Fwd1_E !== 2'd2) begin failures++; $display("FAIL lu_fwd_w: got %0d expected 2", Fwd1_E); end
    checks++; if (StallCnt !== 16'd1) begin failures++; $display("FAIL lu_stallcnt_hold: got %0d expected 1", StallCnt); end
    next_cycle();
    set_idle();
  endtask

  task automatic test_forwarding();
    set_idle();
    WEN_M = 0; WA_M = 5; Load_M = 0; WEN_W = 0; WA_W = 5; RA0_E = 5; RA1_E = 9;
    @(negedge CLK);
    checks++; if (Fwd0_E !== 2'd1) begin failures++; $display("FAIL fwd_m_prio: got %0d expected 1", Fwd0_E); end
    checks++; if (Fwd1_E !== 2'd0) begin failures++; $display("FAIL fwd_none: got %0d expected 0", Fwd1_E); end
    Load_M = 1;
    #1;
    checks++; if (Fwd0_E !== 2'd2) begin failures++; $display("FAIL fwd_load_in_m: got %0d expected 2", Fwd0_E); end
    Load_M = 0; WA_M = 0; RA1_E = 0; WA_W = 0; RA0_E = 31;
    #1;
    checks++; if (Fwd1_E !== 2'd1 || Fwd0_E !== 2'd0) begin failures++; $display("FAIL fwd_r0: got %0d/%0d expected 1/0", Fwd1_E, Fwd0_E); end
    WEN_M = 1;
    #1;
    checks++; if (Fwd1_E !== 2'd2) begin failures++; $display("FAIL fwd_w_only: got %0d expected 2", Fwd1_E); end
    next_cycle();
    set_idle();
  endtask

  task automatic test_branch_lu();
    do_reset();
    BrTaken_E = 1; Load_E = 1; WEN_E = 0; WA_E = 8; RA0_D = 8; Use0_D = 1;
    @(negedge CLK);
    checks++; if (ctrl !== C_BR) begin failures++; $display("FAIL br_over_lu: got %b expected %b", ctrl, C_BR); end
    next_cycle();
    set_idle();
    @(negedge CLK);
    checks++; if (StallCnt !== 16'd0) begin failures++; $display("FAIL br_no_stall: got %0d expected 0", StallCnt); end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    DREQ_M = 0; DRDY = 1;
    @(negedge CLK);
    checks++; if (ctrl !== C_NORM) begin failures++; $display("FAIL mem_fast: got %b expected %b", ctrl, C_NORM); end
    next_cycle();
    DREQ_M = 0; DRDY = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (ctrl !== C_HOLD) begin failures++; $display("FAIL mem_hold_%0d: got %b expected %b", i, ctrl, C_HOLD); end
      next_cycle();
    end
    DRDY = 1;
    @(negedge CLK);
    checks++; if (ctrl !== C_NORM || dbg_state !== 1'b1) begin failures++; $display("FAIL mem_resume: got %b st=%0d expected %b st=1", ctrl, dbg_state, C_NORM); end
    next_cycle();
    set_idle();
    @(negedge CLK);
    checks++; if (StallCnt !== 16'd3 || MemErr !== 1'b0 || dbg_state !== 1'b0) begin failures++; $display("FAIL mem_after: cnt=%0d err=%0d st=%0d expected 3/0/0", StallCnt, MemErr, dbg_state); end
    next_cycle();
  endtask

  task automatic test_timeout();
    int n;
    bit done;
    do_reset();
    DREQ_M = 0; DRDY = 0;
    n = 0; done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (PCWrite === 1'b1) begin done = 1; break; end
      n++;
      next_cycle();
    end
    checks++; if (n != TIMEOUT || !done) begin failures++; $display("FAIL tmo_stall_len: got %0d expected %0d", n, TIMEOUT); end
    checks++; if (MemErr !== 1'b0) begin failures++; $display("FAIL tmo_err_early: got %0d expected 0", MemErr); end
    next_cycle();
    set_idle();
    @(negedge CLK);
    checks++; if (MemErr !== 1'b1 || dbg_state !== 1'b0 || StallCnt !== 16'd4) begin failures++; $display("FAIL tmo_after: err=%0d st=%0d cnt=%0d expected 1/0/4", MemErr, dbg_state, StallCnt); end
    checks++; if (ctrl !== C_NORM) begin failures++; $display("FAIL tmo_ctrl: got %b expected %b", ctrl, C_NORM); end
    next_cycle();
    @(negedge CLK);
    checks++; if (MemErr !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %0d expected 1", MemErr); end
    next_cycle();
  endtask

  // Runs straight after the timeout scenario so MemErr starts out set.
  task automatic test_reset_mid_wait();
    DREQ_M = 0; DRDY = 0;
    @(negedge CLK);
    next_cycle();
    @(negedge CLK);
    checks++; if (dbg_state !== 1'b1) begin failures++; $display("FAIL rmw_in_wait: got %0d expected 1", dbg_state); end
    #1;
    WEN_M = 0; WA_M = 4; RA0_E = 4;
    RSTN = 0;
    #1;
    checks++; if (ctrl !== C_RESET || Fwd0_E !== 2'd0) begin failures++; $display("FAIL rmw_outputs: got %b fwd=%0d expected %b fwd=0", ctrl, Fwd0_E, C_RESET); end
    checks++; if (MemErr !== 1'b0 || StallCnt !== 16'd0 || dbg_state !== 1'b0) begin failures++; $display("FAIL rmw_state: err=%0d cnt=%0d st=%0d expected 0/0/0", MemErr, StallCnt, dbg_state); end
    set_idle();
    @(posedge CLK); #1;
    RSTN = 1;
    @(negedge CLK);
    checks++; if (ctrl !== C_NORM || StallCnt !== 16'd0 || dbg_state !== 1'b0) begin failures++; $display("FAIL rmw_release: ctrl=%b cnt=%0d st=%0d expected %b/0/0", ctrl, StallCnt, dbg_state, C_NORM); end
    next_cycle();
  endtask

  // ---------------- randomized run against a reference model ----------------
  // Model state: how many cycles the current memory access has already
  // stalled the pipeline (0 = no access in progress), the sticky error and
  // the number of cycles with PCWrite low.
  task automatic test_random();
    int waited, cnt_ref, exp_fwd0, exp_fwd1;
    bit err_ref, hold, lu;
    logic [6:0] exp_ctrl;
    do_reset();
    waited = 0; cnt_ref = 0; err_ref = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      RA0_D = 5'($urandom_range(0, 3)); RA1_D = 5'($urandom_range(0, 3));
      Use0_D = 1'($urandom_range(0, 1)); Use1_D = 1'($urandom_range(0, 1));
      RA0_E = 5'($urandom_range(0, 3)); RA1_E = 5'($urandom_range(0, 3));
      WA_E = 5'($urandom_range(0, 3)); WA_M = 5'($urandom_range(0, 3)); WA_W = 5'($urandom_range(0, 3));
      WEN_E = 1'($urandom_range(0, 1)); WEN_M = 1'($urandom_range(0, 1)); WEN_W = 1'($urandom_range(0, 1));
      Load_E = 1'($urandom_range(0, 1)); Load_M = 1'($urandom_range(0, 1));
      BrTaken_E = ($urandom_range(0, 5) == 0);
      // A stalled access keeps its request asserted in M.
      DREQ_M = (waited > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      DRDY = ($urandom_range(0, 4) == 0);

      hold = !DREQ_M && !DRDY && (waited < TIMEOUT);
      lu = Load_E && !WEN_E && ((Use0_D && RA0_D == WA_E) || (Use1_D && RA1_D == WA_E));
      if (hold) exp_ctrl = C_HOLD;
      else if (BrTaken_E) exp_ctrl = C_BR;
      else if (lu) exp_ctrl = C_LU;
      else exp_ctrl = C_NORM;
      exp_fwd0 = (!WEN_M && !Load_M && WA_M == RA0_E) ? 1 : (!WEN_W && WA_W == RA0_E) ? 2 : 0;
      exp_fwd1 = (!WEN_M && !Load_M && WA_M == RA1_E) ? 1 : (!WEN_W && WA_W == RA1_E) ? 2 : 0;

      @(negedge CLK);
      checks++; if (ctrl !== exp_ctrl) begin failures++; $display("FAIL rnd_ctrl cyc %0d: got %b expected %b", cyc, ctrl, exp_ctrl); end
      checks++; if (Fwd0_E !== 2'(exp_fwd0) || Fwd1_E !== 2'(exp_fwd1)) begin failures++; $display("FAIL rnd_fwd cyc %0d: got %0d/%0d expected %0d/%0d", cyc, Fwd0_E, Fwd1_E, exp_fwd0, exp_fwd1); end
      checks++; if (StallCnt !== 16'(cnt_ref)) begin failures++; $display("FAIL rnd_stallcnt cyc %0d: got %0d expected %0d", cyc, StallCnt, cnt_ref); end
      checks++; if (MemErr !== err_ref) begin failures++; $display("FAIL rnd_memerr cyc %0d: got %0d expected %0d", cyc, MemErr, err_ref); end
      checks++; if (dbg_state !== (waited > 0)) begin failures++; $display("FAIL rnd_state cyc %0d: got %0d expected %0d", cyc, dbg_state, (waited > 0)); end

      if (!exp_ctrl[6] && cnt_ref < 65535) cnt_ref++;
      if (hold) begin
        waited++;
      end else begin
        if (waited == TIMEOUT && !DRDY) err_ref = 1;
        waited = 0;
      end
      next_cycle();
    end
    set_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
